dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the execute unit's load/store interface and a secondary requester (program loader / debug port). It sits between the execute stage and the data RAM. It picks one access per cycle and tracks outstanding reads against the RAM's 1-cycle read latency. It stalls the execute stage while its access is pending and bounds starvation of the secondary port with a streak counter.

## Interface
- D_BITS, 32, data width
- A_BITS, 10, address width
- MAX_WAIT, 4, consecutive contested cycles the execute port may win before the secondary port is forced through (range 1-15)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ex_read  in  1  execute-stage load request
- ex_write  in  1  execute-stage store request
- ex_address  in  A_BITS  execute-stage address
- ex_data_out  in  D_BITS  execute-stage store data
- ex_stall  out  1  hold execute stage (its request not yet satisfied)
- ex_rdata  out  D_BITS  load data to execute stage
- ex_rvalid  out  1  ex_rdata valid this cycle
- ld_req  in  1  secondary request, held until ld_gnt
- ld_we  in  1  secondary write enable
- ld_addr  in  A_BITS  secondary address
- ld_wdata  in  D_BITS  secondary write data
- ld_gnt  out  1  secondary request accepted this cycle
- ld_rdata  out  D_BITS  secondary read data
- ld_rvalid  out  1  ld_rdata valid this cycle
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  A_BITS  RAM address
- mem_wdata  out  D_BITS  RAM write data
- mem_rdata  in  D_BITS  RAM read data, valid one cycle after a read with mem_en=1, mem_we=0

## Operation
- Execute request active = (ex_read | ex_write), excluding the case where state is EX_RD (that read is already issued and is completing).
- If ex_read and ex_write are both high, the request is treated as a write.
- One grant per cycle. The RAM controls mem_en/mem_we/mem_addr/mem_wdata are combinational from the winning request. When nothing is granted: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Priority: execute port wins a contested cycle unless streak == MAX_WAIT, in which case the secondary port wins.
- streak (4-bit register) rules:
  - increments when both ports contend and execute wins;
  - clears when ld_gnt=1 or when ld_req=0;
  - saturates at MAX_WAIT.
- FSM states (registered):
  - IDLE: no read outstanding.
  - EX_RD: execute read issued last cycle.
  - LD_RD: secondary read issued last cycle.
- Next state: EX_RD if an execute read is granted; LD_RD if a secondary read is granted; otherwise IDLE. Transitions are taken from any state, because the RAM is pipelined and a new access can issue while a read is completing.
- EX_RD outputs: ex_rvalid=1 and ex_rdata=mem_rdata. The execute port is not counted as contending, so a pending ld_req is granted that cycle.
- LD_RD outputs: ld_rvalid=1 and ld_rdata=mem_rdata.
- ex_rdata and ld_rdata are 0 when their rvalid is 0.
- ex_stall = execute request active AND not granted, OR execute read granted this cycle. The stall drops in the EX_RD cycle.
- Execute write granted: ex_stall=0 that cycle and the write completes in that cycle.
- ld_gnt is combinational. A secondary write completes in its ld_gnt cycle.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, streak=0;
  - ex_rvalid=0, ld_rvalid=0;
  - outstanding reads are discarded, with no rvalid after reset deasserts.
  - Combinational outputs follow their inputs.
- Execute load latency: 2 cycles (grant cycle with stall, then data cycle with rvalid, no stall), plus 1 cycle for each lost arbitration.
- Execute store latency: 1 cycle uncontested.
- Secondary read: data arrives with ld_rvalid exactly 1 cycle after ld_gnt.
- Worst-case secondary wait: MAX_WAIT+1 cycles under continuous execute traffic.
- Worst-case execute wait: 1 extra cycle per forced secondary grant.
- Back-to-back reads from alternating ports reach full throughput of one access per cycle.

## Test plan
- Reset mid-read: rst pulsed in the cycle after an execute read grant -> ex_rvalid=0 and state IDLE; no rvalid appears afterwards.
- Lone execute load, addr 0x005, RAM[5]=0xDEADBEEF:
  - cycle N: mem_en=1, mem_we=0, ex_stall=1;
  - cycle N+1: ex_rvalid=1, ex_rdata=0xDEADBEEF, ex_stall=0.
- Lone execute store, addr 0x010, data 0x12345678 -> same cycle: mem_en=1, mem_we=1, mem_wdata=0x12345678, ex_stall=0; a later read returns the value.
- Contention with ld_req held and continuous execute stores (MAX_WAIT=4) -> execute wins 4 cycles; cycle 5: ld_gnt=1, ex_stall=1; cycle 6: execute wins again and streak=0.
- Execute load during EX_RD with ld_req pending -> in the EX_RD cycle ld_gnt=1 and ex_rvalid=1 together, and no extra execute stall.
- Simultaneous ex_read and ex_write -> mem_we=1, no rvalid generated.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the execute stage's
// load/store port and a secondary (loader/debug) port. One access is granted
// per cycle. Reads have one cycle of latency, and a streak counter limits how
// long the secondary port can be starved.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no read outstanding
// EX_RD | execute read issued last cycle, data on mem_rdata now
// LD_RD | secondary read issued last cycle, data on mem_rdata now
module dmem_arbiter #(
   parameter int D_BITS   = 32,
   parameter int A_BITS   = 10,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_read,
   input  logic              ex_write,
   input  logic [A_BITS-1:0] ex_address,
   input  logic [D_BITS-1:0] ex_data_out,
   output logic              ex_stall,
   output logic [D_BITS-1:0] ex_rdata,
   output logic              ex_rvalid,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [A_BITS-1:0] ld_addr,
   input  logic [D_BITS-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic [D_BITS-1:0] ld_rdata,
   output logic              ld_rvalid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [A_BITS-1:0] mem_addr,
   output logic [D_BITS-1:0] mem_wdata,
   input  logic [D_BITS-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EX_RD = 2'd1,
      LD_RD = 2'd2
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_WAIT);

   state_t     state;
   logic [3:0] streak;
   logic       ex_act;
   logic       ex_win;
   logic       ld_win;

   // Arbitration. The execute read completing in EX_RD is already issued,
   // so it does not compete, which lets a waiting secondary request through.
   always_comb begin
      ex_act = (ex_read | ex_write) && (state != EX_RD);
      ld_win = ld_req && (!ex_act || (streak == STREAK_MAX));
      ex_win = ex_act && !ld_win;
   end

   // RAM controls and port handshakes, driven straight from the winner.
   // A simultaneous read+write from execute is treated as a write.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (ex_win) begin
         mem_en    = 1'b1;
         mem_we    = ex_write;
         mem_addr  = ex_address;
         mem_wdata = ex_data_out;
      end else if (ld_win) begin
         mem_en    = 1'b1;
         mem_we    = ld_we;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end
      ld_gnt   = ld_win;
      ex_stall = (ex_act && !ex_win) || (ex_win && !ex_write);
      ex_rdata = ex_rvalid ? mem_rdata : '0;
      ld_rdata = ld_rvalid ? mem_rdata : '0;
   end

   // Read-tracking FSM, registered rvalid flags and the starvation streak.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= 4'd0;
         ex_rvalid <= 1'b0;
         ld_rvalid <= 1'b0;
      end else begin
         ex_rvalid <= 1'b0;
         ld_rvalid <= 1'b0;
         if (ex_win && !ex_write) begin
            state     <= EX_RD;
            ex_rvalid <= 1'b1;
         end else if (ld_win && !ld_we) begin
            state     <= LD_RD;
            ld_rvalid <= 1'b1;
         end else begin
            state <= IDLE;
         end

         if (ld_win || !ld_req)
            streak <= 4'd0;
         else if (ex_win && (streak != STREAK_MAX))
            streak <= streak + 4'd1;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_dmem_arbiter;

   localparam int D_BITS   = 32;
   localparam int A_BITS   = 10;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              ex_read, ex_write;
   logic [A_BITS-1:0] ex_address;
   logic [D_BITS-1:0] ex_data_out;
   logic              ex_stall;
   logic [D_BITS-1:0] ex_rdata;
   logic              ex_rvalid;
   logic              ld_req, ld_we;
   logic [A_BITS-1:0] ld_addr;
   logic [D_BITS-1:0] ld_wdata;
   logic              ld_gnt;
   logic [D_BITS-1:0] ld_rdata;
   logic              ld_rvalid;
   logic              mem_en, mem_we;
   logic [A_BITS-1:0] mem_addr;
   logic [D_BITS-1:0] mem_wdata;
   logic [D_BITS-1:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   // bench-side RAM with a backdoor for preloading
   logic [D_BITS-1:0] ram [0:(1<<A_BITS)-1];
   logic              bd_we = 1'b0;
   logic [A_BITS-1:0] bd_addr = '0;
   logic [D_BITS-1:0] bd_data = '0;

   // reference memory of the random run
   logic [D_BITS-1:0] ref_mem [0:15];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
   end

   dmem_arbiter #(.D_BITS(D_BITS), .A_BITS(A_BITS), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .ex_read(ex_read), .ex_write(ex_write), .ex_address(ex_address),
      .ex_data_out(ex_data_out), .ex_stall(ex_stall), .ex_rdata(ex_rdata),
      .ex_rvalid(ex_rvalid),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic idle_inputs();
      ex_read = 0; ex_write = 0; ex_address = '0; ex_data_out = '0;
      ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
   endtask

   task automatic backdoor(input logic [A_BITS-1:0] a, input logic [D_BITS-1:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      ld_req = 1; ld_addr = 10'h003;
      repeat (2) @(negedge clk);
      #2;
      n_cmp++; if (ex_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_rvalid got %0b want 0", ex_rvalid); end
      n_cmp++; if (ld_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_ld_rvalid got %0b want 0", ld_rvalid); end
      n_cmp++; if (ex_stall !== 1'b0) begin n_bad++; $display("FAIL reset_ex_stall got %0b want 0", ex_stall); end
      n_cmp++; if (ld_gnt !== 1'b1 || mem_addr !== 10'h003) begin n_bad++; $display("FAIL reset_comb_follow gnt=%0b addr=%h want 1 003", ld_gnt, mem_addr); end
      idle_inputs();
      #1;
      n_cmp++; if (mem_en !== 1'b0 || mem_addr !== '0) begin n_bad++; $display("FAIL reset_mem_idle en=%0b addr=%h want 0 000", mem_en, mem_addr); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lone_load();
      backdoor(10'h005, 32'hDEADBEEF);
      @(negedge clk);
      ex_read = 1; ex_address = 10'h005;
      #2;
      n_cmp++; if ({mem_en, mem_we, ex_stall} !== 3'b101 || mem_addr !== 10'h005) begin n_bad++; $display("FAIL load_grant en/we/stall=%b addr=%h want 101 005", {mem_en, mem_we, ex_stall}, mem_addr); end
      @(negedge clk); #2;
      n_cmp++; if (ex_rvalid !== 1'b1 || ex_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_data rvalid=%0b data=%h want 1 deadbeef", ex_rvalid, ex_rdata); end
      n_cmp++; if (ex_stall !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL load_data_stall stall=%0b en=%0b want 0 0", ex_stall, mem_en); end
      @(negedge clk);
      idle_inputs();
      #2;
      n_cmp++; if (ex_rvalid !== 1'b0 || ex_rdata !== '0) begin n_bad++; $display("FAIL load_after rvalid=%0b data=%h want 0 0", ex_rvalid, ex_rdata); end
   endtask

   task automatic test_lone_store();
      @(negedge clk);
      ex_write = 1; ex_address = 10'h010; ex_data_out = 32'h12345678;
      #2;
      n_cmp++; if ({mem_en, mem_we, ex_stall} !== 3'b110 || mem_wdata !== 32'h12345678 || mem_addr !== 10'h010) begin n_bad++; $display("FAIL store en/we/stall=%b wdata=%h want 110 12345678", {mem_en, mem_we, ex_stall}, mem_wdata); end
      @(negedge clk);
      idle_inputs(); ex_read = 1; ex_address = 10'h010;
      @(negedge clk); #2;
      n_cmp++; if (ex_rvalid !== 1'b1 || ex_rdata !== 32'h12345678) begin n_bad++; $display("FAIL store_readback rvalid=%0b data=%h want 1 12345678", ex_rvalid, ex_rdata); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_contention();
      backdoor(10'h020, 32'hCAFEF00D);
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         ex_write = 1; ex_address = 10'(10'h040 + cyc); ex_data_out = 32'(cyc);
         ld_req = 1; ld_we = 0; ld_addr = 10'h020;
         #2;
         begin
            logic exp_ld;
            exp_ld = (cyc == 5) || (cyc == 10);
            n_cmp++; if (ld_gnt !== exp_ld || ex_stall !== exp_ld) begin n_bad++; $display("FAIL contention_c%0d gnt=%0b stall=%0b want %0b %0b", cyc, ld_gnt, ex_stall, exp_ld, exp_ld); end
            n_cmp++; if (mem_addr !== (exp_ld ? 10'h020 : 10'(10'h040 + cyc))) begin n_bad++; $display("FAIL contention_addr_c%0d got %h", cyc, mem_addr); end
            if (cyc == 6) begin
               n_cmp++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL contention_ld_data rvalid=%0b data=%h want 1 cafef00d", ld_rvalid, ld_rdata); end
            end
         end
      end
      @(negedge clk);
      idle_inputs();
      #2;
      n_cmp++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL contention_ld_data2 rvalid=%0b data=%h", ld_rvalid, ld_rdata); end
   endtask

   task automatic test_load_during_ex_rd();
      backdoor(10'h007, 32'h07070707);
      backdoor(10'h008, 32'h08080808);
      backdoor(10'h009, 32'h09090909);
      @(negedge clk);
      ex_read = 1; ex_address = 10'h007;
      ld_req = 1; ld_we = 0; ld_addr = 10'h008;
      #2;
      n_cmp++; if (ld_gnt !== 1'b0 || ex_stall !== 1'b1) begin n_bad++; $display("FAIL exrd_first gnt=%0b stall=%0b want 0 1", ld_gnt, ex_stall); end
      @(negedge clk); #2;
      n_cmp++; if (ld_gnt !== 1'b1 || ex_rvalid !== 1'b1 || ex_rdata !== 32'h07070707 || ex_stall !== 1'b0 || mem_addr !== 10'h008) begin n_bad++; $display("FAIL exrd_overlap gnt=%0b rv=%0b data=%h stall=%0b addr=%h", ld_gnt, ex_rvalid, ex_rdata, ex_stall, mem_addr); end
      @(negedge clk);
      ld_req = 0; ex_address = 10'h009;
      #2;
      n_cmp++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h08080808 || mem_addr !== 10'h009 || ex_stall !== 1'b1) begin n_bad++; $display("FAIL exrd_alternate ld_rv=%0b data=%h addr=%h stall=%0b", ld_rvalid, ld_rdata, mem_addr, ex_stall); end
      @(negedge clk); #2;
      n_cmp++; if (ex_rvalid !== 1'b1 || ex_rdata !== 32'h09090909) begin n_bad++; $display("FAIL exrd_third rv=%0b data=%h want 1 09090909", ex_rvalid, ex_rdata); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_rw_simultaneous();
      @(negedge clk);
      ex_read = 1; ex_write = 1; ex_address = 10'h030; ex_data_out = 32'h55AA55AA;
      #2;
      n_cmp++; if (mem_we !== 1'b1 || mem_en !== 1'b1 || ex_stall !== 1'b0) begin n_bad++; $display("FAIL rw_write we=%0b en=%0b stall=%0b want 1 1 0", mem_we, mem_en, ex_stall); end
      @(negedge clk);
      idle_inputs();
      #2;
      n_cmp++; if (ex_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin n_bad++; $display("FAIL rw_no_rvalid ex=%0b ld=%0b want 0 0", ex_rvalid, ld_rvalid); end
      ex_read = 1; ex_address = 10'h030;
      @(negedge clk); #2;
      n_cmp++; if (ex_rdata !== 32'h55AA55AA) begin n_bad++; $display("FAIL rw_readback got %h want 55aa55aa", ex_rdata); end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      ex_read = 1; ex_address = 10'h005;
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #2;
      n_cmp++; if (ex_rvalid !== 1'b0 || ex_rdata !== '0) begin n_bad++; $display("FAIL midread_rst rvalid=%0b data=%h want 0 0", ex_rvalid, ex_rdata); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #2;
         n_cmp++; if (ex_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin n_bad++; $display("FAIL midread_after%0d ex=%0b ld=%0b want 0 0", i, ex_rvalid, ld_rvalid); end
      end
   endtask

   // Reference model: the execute port owns the RAM unless the secondary
   // port has already lost MAX_WAIT contested cycles in a row; the cycle
   // after an execute read grant is that read's data cycle, in which the
   // execute port is not competing.
   task automatic test_random();
      logic [1:0]        ex_op;
      logic [3:0]        ex_a;
      logic [D_BITS-1:0] ex_d;
      logic              ld_on, ld_w;
      logic [3:0]        ld_a;
      logic [D_BITS-1:0] ld_d;
      logic              m_ex_rd, m_ld_rd;
      logic [D_BITS-1:0] m_ex_val, m_ld_val;
      int                losses;
      logic              act, lwin, ewin, is_wr, ex_done;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         backdoor(10'(i), ref_mem[i]);
      end
      ex_op = 2'b00; ex_a = 0; ex_d = 0;
      ld_on = 0; ld_w = 0; ld_a = 0; ld_d = 0;
      m_ex_rd = 0; m_ld_rd = 0; m_ex_val = 0; m_ld_val = 0; losses = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         ex_read = ex_op[0]; ex_write = ex_op[1]; ex_address = 10'(ex_a); ex_data_out = ex_d;
         ld_req = ld_on; ld_we = ld_w; ld_addr = 10'(ld_a); ld_wdata = ld_d;
         #2;
         is_wr = ex_op[1];
         act   = (ex_op != 2'b00) && !m_ex_rd;
         lwin  = ld_on && (!act || losses >= MAX_WAIT);
         ewin  = act && !lwin;
         n_cmp++; if (ld_gnt !== lwin) begin n_bad++; $display("FAIL rnd_gnt c%0d got %0b want %0b", cyc, ld_gnt, lwin); end
         n_cmp++; if (ex_stall !== (act && !(ewin && is_wr))) begin n_bad++; $display("FAIL rnd_stall c%0d got %0b want %0b", cyc, ex_stall, act && !(ewin && is_wr)); end
         n_cmp++; if (ex_rvalid !== m_ex_rd || ex_rdata !== (m_ex_rd ? m_ex_val : '0)) begin n_bad++; $display("FAIL rnd_ex_rd c%0d rv=%0b data=%h want %0b %h", cyc, ex_rvalid, ex_rdata, m_ex_rd, m_ex_rd ? m_ex_val : '0); end
         n_cmp++; if (ld_rvalid !== m_ld_rd || ld_rdata !== (m_ld_rd ? m_ld_val : '0)) begin n_bad++; $display("FAIL rnd_ld_rd c%0d rv=%0b data=%h want %0b %h", cyc, ld_rvalid, ld_rdata, m_ld_rd, m_ld_rd ? m_ld_val : '0); end
         if (ewin) begin
            n_cmp++; if ({mem_en, mem_we} !== {1'b1, is_wr} || mem_addr !== 10'(ex_a) || mem_wdata !== ex_d) begin n_bad++; $display("FAIL rnd_mem_ex c%0d en/we=%b addr=%h", cyc, {mem_en, mem_we}, mem_addr); end
         end else if (lwin) begin
            n_cmp++; if ({mem_en, mem_we} !== {1'b1, ld_w} || mem_addr !== 10'(ld_a) || mem_wdata !== ld_d) begin n_bad++; $display("FAIL rnd_mem_ld c%0d en/we=%b addr=%h", cyc, {mem_en, mem_we}, mem_addr); end
         end else begin
            n_cmp++; if ({mem_en, mem_we} !== 2'b00 || mem_addr !== '0 || mem_wdata !== '0) begin n_bad++; $display("FAIL rnd_mem_idle c%0d en/we=%b addr=%h", cyc, {mem_en, mem_we}, mem_addr); end
         end
         ex_done = (ex_op == 2'b00) || m_ex_rd || (ewin && is_wr);
         m_ex_rd  = ewin && !is_wr;
         m_ex_val = ref_mem[ex_a];
         m_ld_rd  = lwin && !ld_w;
         m_ld_val = ref_mem[ld_a];
         if (ewin && is_wr) ref_mem[ex_a] = ex_d;
         if (lwin && ld_w)  ref_mem[ld_a] = ld_d;
         if (lwin || !ld_on) losses = 0;
         else if (act) losses++;
         if (ex_done) begin
            ex_op = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            ex_a  = 4'($urandom_range(0, 15));
            ex_d  = $urandom;
         end
         if (lwin || !ld_on) begin
            ld_on = ($urandom_range(0, 2) != 0);
            ld_w  = 1'($urandom_range(0, 1));
            ld_a  = 4'($urandom_range(0, 15));
            ld_d  = $urandom;
         end
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_lone_load();
      test_lone_store();
      test_contention();
      test_load_during_ex_rd();
      test_rw_simultaneous();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
